// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The optional IFQ_BYPASS_EN macro, consumed by inst_fetch_queue, enables
// the zero-latency empty-queue bypass.
package ifq_pkg;

    localparam int IFQ_DATA_W = 32;
    localparam int IFQ_ADDR_W = 32;
    localparam int IFQ_DEPTH  = 4;

    // One buffered fetch result: the PC and the instruction word fetched there.
    typedef struct packed {
        logic [IFQ_ADDR_W-1:0] pc;
        logic [IFQ_DATA_W-1:0] instr;
    } ifq_entry_t;

    // Pointer width: one index bit per log2(depth) plus a wrap bit, so that
    // full and empty can be told apart when the index bits are equal.
    function automatic int ifq_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifq_mem.sv
// Entry storage for the instruction fetch queue: DEPTH registers, one
// synchronous write port, one asynchronous read port, no reset.
module ifq_mem
    import ifq_pkg::*;
#(
    parameter int ENTRY_W = IFQ_ADDR_W + IFQ_DATA_W,
    parameter int DEPTH   = IFQ_DEPTH,
    parameter int IDX_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] entries [DEPTH];

    // Write the pushed entry; contents survive reset and flush because the
    // pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            entries[wr_idx] <= wr_data;
        end
    end

    assign rd_data = entries[rd_idx];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between instruction-memory read-out and IF/ID.
// Circular buffer of {PC, instruction} pairs with valid/ready on both sides
// and a single-cycle flush for branch/exception redirects.
// Optional macro IFQ_BYPASS_EN: when the queue is empty, an offered push is
// presented on the pop side in the same cycle.
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int DATA_W = IFQ_DATA_W,
    parameter int ADDR_W = IFQ_ADDR_W,
    parameter int DEPTH  = IFQ_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              flush,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_instr,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [ADDR_W-1:0] pop_pc,
    output logic [DATA_W-1:0] pop_instr,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W   = ifq_ptr_w(DEPTH);
    localparam int IDX_W   = PTR_W - 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               empty;
    logic               full;
    logic               push_fire;
    logic               pop_fire;
    logic               mem_wr_en;
    logic               rd_advance;
    logic [ENTRY_W-1:0] mem_rd_data;
    logic [ADDR_W-1:0]  mem_pc;
    logic [DATA_W-1:0]  mem_instr;

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[IDX_W-1:0] == wr_ptr[IDX_W-1:0]) &&
                   (rd_ptr[PTR_W-1] != wr_ptr[PTR_W-1]);

    assign mem_pc    = mem_rd_data[ENTRY_W-1:DATA_W];
    assign mem_instr = mem_rd_data[DATA_W-1:0];

    // push_ready looks only at the registered full flag, so a pop in the
    // same cycle never frees a slot early.
    assign push_ready = !full && !flush;
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop_valid && pop_ready;

`ifdef IFQ_BYPASS_EN
    logic bypass;

    // An empty queue forwards the offered push straight to the consumer.
    // If it is taken at once nothing is stored and the pointers stay put.
    assign bypass     = empty && !flush && push_valid;
    assign pop_valid  = (!empty && !flush) || bypass;
    assign pop_pc     = bypass ? push_pc    : mem_pc;
    assign pop_instr  = bypass ? push_instr : mem_instr;
    assign mem_wr_en  = push_fire && !(bypass && pop_ready);
    assign rd_advance = pop_fire && !bypass;
`else
    // Registered-only pop side: the head entry comes from storage.
    assign pop_valid  = !empty && !flush;
    assign pop_pc     = mem_pc;
    assign pop_instr  = mem_instr;
    assign mem_wr_en  = push_fire;
    assign rd_advance = pop_fire;
`endif

    // Pointer update: reset wins over flush, and both return the queue to
    // empty; otherwise each side advances on its own transfer.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (mem_wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_advance) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // The handshake keeps the difference within 0..DEPTH, so no saturation.
    assign count = CNT_W'(wr_ptr - rd_ptr);

    ifq_mem #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH),
        .IDX_W   (IDX_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_idx  (wr_ptr[IDX_W-1:0]),
        .wr_data ({push_pc, push_instr}),
        .rd_idx  (rd_ptr[IDX_W-1:0]),
        .rd_data (mem_rd_data)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue (DEPTH = 4).
// Inputs change on the falling edge, outputs are compared 1 ns later,
// and the state update happens on the following rising edge.
module tb_inst_fetch_queue;
    import ifq_pkg::*;

`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        arst_n;
    logic        flush;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_pc;
    logic [31:0] push_instr;
    logic        pop_valid;
    logic        pop_ready;
    logic [31:0] pop_pc;
    logic [31:0] pop_instr;
    logic [2:0]  count;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        logic        fl;
        logic        pv;
        logic [31:0] pc;
        logic        pr;
        logic        e_pv;
        logic        e_prdy;
        logic [2:0]  e_cnt;
        logic        chk_pc;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs [22];

    inst_fetch_queue dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .flush      (flush),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_pc    (push_pc),
        .push_instr (push_instr),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_pc     (pop_pc),
        .pop_instr  (pop_instr),
        .count      (count)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word paired with each PC, so the data path is checked too.
    function automatic ifq_entry_t entry_of(input logic [31:0] pc);
        ifq_entry_t e;
        e.pc    = pc;
        e.instr = pc ^ 32'hC0DE_5A00;
        return e;
    endfunction

    function automatic vec_t mkv(input logic fl, input logic pv, input logic [31:0] pc,
                                 input logic pr, input logic e_pv, input logic e_prdy,
                                 input logic [2:0] e_cnt, input logic chk_pc,
                                 input logic [31:0] e_pc);
        vec_t v;
        v.fl = fl; v.pv = pv; v.pc = pc; v.pr = pr;
        v.e_pv = e_pv; v.e_prdy = e_prdy; v.e_cnt = e_cnt;
        v.chk_pc = chk_pc; v.e_pc = e_pc;
        return v;
    endfunction

    // Drive one cycle of inputs on the falling edge and let them settle.
    task automatic applyStimulus(input logic fl, input logic pv, input logic [31:0] pc,
                                 input logic pr);
        ifq_entry_t e;
        @(negedge clk);
        e          = entry_of(pc);
        flush      = fl;
        push_valid = pv;
        push_pc    = e.pc;
        push_instr = e.instr;
        pop_ready  = pr;
        #1;
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        check_count++;
        if (got === want) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Compare the settled outputs for the current cycle.
    task automatic checkOutput(input string name, input logic e_pv, input logic e_prdy,
                               input logic [2:0] e_cnt, input logic chk_pc,
                               input logic [31:0] e_pc);
        ifq_entry_t e;
        cmp({name, " pop_valid"}, 32'(pop_valid), 32'(e_pv));
        cmp({name, " push_ready"}, 32'(push_ready), 32'(e_prdy));
        cmp({name, " count"}, 32'(count), 32'(e_cnt));
        if (chk_pc) begin
            e = entry_of(e_pc);
            cmp({name, " pop_pc"}, pop_pc, e.pc);
            cmp({name, " pop_instr"}, pop_instr, e.instr);
        end
    endtask

    initial begin
        arst_n     = 1'b0;
        flush      = 1'b0;
        push_valid = 1'b0;
        push_pc    = '0;
        push_instr = '0;
        pop_ready  = 1'b0;

        // Fill to full, refuse a fifth push, drain in order.
        vecs[0]  = mkv(0, 1, 32'h00, 0, BYP, 1, 0, BYP, 32'h00);
        vecs[1]  = mkv(0, 1, 32'h04, 0, 1, 1, 1, 1, 32'h00);
        vecs[2]  = mkv(0, 1, 32'h08, 0, 1, 1, 2, 1, 32'h00);
        vecs[3]  = mkv(0, 1, 32'h0C, 0, 1, 1, 3, 1, 32'h00);
        vecs[4]  = mkv(0, 1, 32'h10, 0, 1, 0, 4, 1, 32'h00);
        vecs[5]  = mkv(0, 0, 32'h00, 1, 1, 0, 4, 1, 32'h00);
        vecs[6]  = mkv(0, 0, 32'h00, 1, 1, 1, 3, 1, 32'h04);
        vecs[7]  = mkv(0, 0, 32'h00, 1, 1, 1, 2, 1, 32'h08);
        vecs[8]  = mkv(0, 0, 32'h00, 1, 1, 1, 1, 1, 32'h0C);
        vecs[9]  = mkv(0, 0, 32'h00, 0, 0, 1, 0, 0, 32'h00);
        // Refill, then pop while full with a push offered: push refused.
        vecs[10] = mkv(0, 1, 32'h20, 0, BYP, 1, 0, BYP, 32'h20);
        vecs[11] = mkv(0, 1, 32'h24, 0, 1, 1, 1, 1, 32'h20);
        vecs[12] = mkv(0, 1, 32'h28, 0, 1, 1, 2, 1, 32'h20);
        vecs[13] = mkv(0, 1, 32'h2C, 0, 1, 1, 3, 1, 32'h20);
        vecs[14] = mkv(0, 1, 32'h30, 1, 1, 0, 4, 1, 32'h20);
        vecs[15] = mkv(0, 1, 32'h30, 0, 1, 1, 3, 1, 32'h24);
        vecs[16] = mkv(0, 0, 32'h00, 0, 1, 0, 4, 1, 32'h24);
        vecs[17] = mkv(0, 0, 32'h00, 1, 1, 0, 4, 1, 32'h24);
        vecs[18] = mkv(0, 0, 32'h00, 1, 1, 1, 3, 1, 32'h28);
        vecs[19] = mkv(0, 0, 32'h00, 1, 1, 1, 2, 1, 32'h2C);
        vecs[20] = mkv(0, 0, 32'h00, 1, 1, 1, 1, 1, 32'h30);
        vecs[21] = mkv(0, 0, 32'h00, 0, 0, 1, 0, 0, 32'h00);

        // Reset held for two edges, then idle.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        applyStimulus(0, 0, 32'h0, 0);
        checkOutput("reset", 0, 1, 0, 0, 32'h0);

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].fl, vecs[i].pv, vecs[i].pc, vecs[i].pr);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_pv, vecs[i].e_prdy,
                        vecs[i].e_cnt, vecs[i].chk_pc, vecs[i].e_pc);
        end

        // Wrap-around: prime one entry, then ten push+pop cycles.
        applyStimulus(0, 1, 32'h100, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 32'h104 + 32'(4 * i), 1);
            checkOutput($sformatf("wrap%0d", i), 1, 1, 1, 1, 32'h100 + 32'(4 * i));
        end
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("wrap_last", 1, 1, 1, 1, 32'h128);
        applyStimulus(0, 0, 32'h0, 0);
        checkOutput("wrap_empty", 0, 1, 0, 0, 32'h0);

        // Flush with three entries and a push offered in the same cycle.
        applyStimulus(0, 1, 32'h50, 0);
        applyStimulus(0, 1, 32'h54, 0);
        applyStimulus(0, 1, 32'h58, 0);
        applyStimulus(1, 1, 32'h5C, 1);
        checkOutput("flush_cycle", 0, 0, 3, 0, 32'h0);
        applyStimulus(0, 0, 32'h0, 0);
        checkOutput("after_flush", 0, 1, 0, 0, 32'h0);
        applyStimulus(0, 1, 32'h200, 0);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("post_flush_pop", 1, 1, 1, 1, 32'h200);
        applyStimulus(0, 0, 32'h0, 0);
        checkOutput("post_flush_empty", 0, 1, 0, 0, 32'h0);

        // Reset mid-operation discards entries like a flush.
        applyStimulus(0, 1, 32'h70, 0);
        applyStimulus(0, 1, 32'h74, 0);
        @(negedge clk);
        push_valid = 1'b0;
        arst_n     = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        checkOutput("mid_reset", 0, 1, 0, 0, 32'h0);

        // Empty queue, push with pop_ready high.
        applyStimulus(0, 1, 32'h40, 1);
        if (BYP) begin
            checkOutput("bypass_same", 1, 1, 0, 1, 32'h40);
            applyStimulus(0, 0, 32'h0, 1);
            checkOutput("bypass_after", 0, 1, 0, 0, 32'h0);
        end else begin
            checkOutput("nobypass_same", 0, 1, 0, 0, 32'h0);
            applyStimulus(0, 0, 32'h0, 1);
            checkOutput("nobypass_next", 1, 1, 1, 1, 32'h40);
            applyStimulus(0, 0, 32'h0, 0);
            checkOutput("nobypass_empty", 0, 1, 0, 0, 32'h0);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch queue between instruction-memory read-out and the IF/ID pipeline register. Buffers up to DEPTH fetched {PC, instruction} pairs so fetch runs ahead while decode is stalled. On a branch redirect (flush) it discards all buffered entries in one cycle. Valid/ready handshake on both sides; the downstream IF/ID register captures on pop_valid && pop_ready.

## Interface
- DATA_W, 32, instruction width in bits
- ADDR_W, 32, PC width in bits
- DEPTH, 4, number of entries; power of two, ≥ 2
- CNT_W, $clog2(DEPTH)+1, width of occupancy count (derived)

- clk  in  1  rising-edge clock, sole clock
- arst_n  in  1  reset, synchronous, active-low; sampled on rising clk only
- flush  in  1  discard all entries (branch/exception redirect)
- push_valid  in  1  upstream presents an entry
- push_ready  out  1  queue accepts an entry this cycle
- push_pc  in  ADDR_W  PC of pushed instruction
- push_instr  in  DATA_W  pushed instruction word
- pop_valid  out  1  head entry valid
- pop_ready  in  1  downstream consumes head
- pop_pc  out  ADDR_W  head PC
- pop_instr  out  DATA_W  head instruction
- count  out  CNT_W  current occupancy, 0..DEPTH

## Operation
- Circular buffer; read pointer rd_ptr, write pointer wr_ptr, each log2(DEPTH)+1 bits (extra wrap bit). empty = pointers equal; full = index bits equal, wrap bits differ.
- Push transfer: push_valid && push_ready; entry written at wr_ptr, wr_ptr += 1 (wrap modulo 2·DEPTH).
- Pop transfer: pop_valid && pop_ready; rd_ptr += 1.
- push_ready = !full && !flush. Depends on current full only, never on pop_ready: no push when full even with a simultaneous pop.
- pop_valid = !empty && !flush. pop_pc/pop_instr = entry at rd_ptr. Held stable while pop_valid && !pop_ready.
- Simultaneous push and pop when neither full nor empty: both occur; count unchanged.
- Flush: next cycle rd_ptr = wr_ptr = 0, count = 0. A push offered in the flush cycle is dropped. No pop transfer occurs in the flush cycle.
- count = wr_ptr − rd_ptr (modular); it saturates at neither end because the handshake prevents overflow and underflow.
- Entries are not cleared on reset or flush; only pointers are reset. pop_pc/pop_instr are don't-care while pop_valid = 0.

## Timing
- Reset: while arst_n = 0 at a clk edge, the next state is rd_ptr = wr_ptr = 0. Outputs after that edge: pop_valid = 0, push_ready = 1, count = 0. Reset has priority over flush, push and pop.
- Reset mid-operation discards all entries exactly as flush does.
- Latency, push to pop_valid: 1 cycle (entry pushed at edge N is visible after edge N).
- Throughput: one push and one pop per cycle sustained.
- push_ready and pop_valid are combinational from registered state plus flush. There is no path from push_valid to pop_valid, and none from pop_ready to push_ready.

## Configuration
- IFQ_BYPASS_EN. When defined and the queue is empty with no flush, push_valid drives pop_valid combinationally, and push_pc/push_instr appear on pop_pc/pop_instr in the same cycle (zero latency).
  - If pop_ready = 1 in that cycle, the entry is not written and the pointers do not move.
  - If pop_ready = 0, the entry is written normally.
- Without IFQ_BYPASS_EN, latency is always 1 cycle and no combinational path from the push side reaches the pop side.

## Structure
- Package ifq_pkg holds:
  - the entry struct ifq_entry_t {pc [ADDR_W], instr [DATA_W]}
  - a pointer-width function
  - default DEPTH/width constants
- One sub-module, ifq_mem: DEPTH × entry register array with one write port, one asynchronous read port, and no reset. Pointer, flag and handshake logic stay in inst_fetch_queue.

## Test plan
- Reset then idle: arst_n = 0 for 2 cycles, then 1 -> pop_valid = 0, push_ready = 1, count = 0.
- Fill with pop_ready = 0: push PCs 0x00, 0x04, 0x08, 0x0C (DEPTH = 4) -> count = 4, push_ready = 0. A fifth push with PC 0x10 is refused. Then draining with pop_ready = 1 yields 0x00, 0x04, 0x08, 0x0C in order and count returns to 0.
- Full with simultaneous pop and push_valid: pop occurs, push refused that cycle -> count = 3, push accepted on the next cycle.
- Wrap-around: 10 continuous push+pop cycles with PCs 0x100, 0x104, … -> output order matches input order, count stays at 1, and no entry is lost across the pointer wrap.
- Flush with 3 entries and a push offered in the same cycle -> next cycle count = 0, pop_valid = 0. The next pushed PC 0x200 is the first popped.
- Bypass, with IFQ_BYPASS_EN defined: empty queue, push PC 0x40 with pop_ready = 1 -> pop_valid = 1 and pop_pc = 0x40 in the same cycle, count stays 0. Without the macro, the same stimulus gives pop_valid one cycle later.
